// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard controller: forward-mux selects,
// MDU tracker states and stall_cause bit positions.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef logic [0:0] mdu_state_t;
    localparam mdu_state_t MDU_IDLE = 1'b0;
    localparam mdu_state_t MDU_BUSY = 1'b1;

    localparam int CAUSE_LOAD_USE = 0;
    localparam int CAUSE_BRANCH   = 1;
    localparam int CAUSE_MDU      = 2;

endpackage

// File: rtl/hazard_mdu_tracker.sv
// Tracks the multi-cycle multiply/divide unit: busy for MDU_LATENCY cycles after a start.
//   state    | meaning
//   MDU_IDLE | no MDU operation in flight
//   MDU_BUSY | operation in flight, cnt = busy cycles remaining after this one
module hazard_mdu_tracker
    import hazard_pkg::*;
#(
    parameter int MDU_LATENCY = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic mdu_start,
    output logic mdu_busy,
    output logic mdu_done
);

    localparam int CW = $clog2(MDU_LATENCY);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LATENCY - 1);

    mdu_state_t    state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MDU_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (mdu_start) begin
                        state <= MDU_BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                default: begin
                    // A start mid-operation is ignored; one on the final cycle chains a new op.
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (mdu_start) begin
                        cnt <= CNT_LOAD;
                    end else begin
                        state <= MDU_IDLE;
                    end
                end
            endcase
        end
    end

    assign mdu_busy = (state == MDU_BUSY);
    assign mdu_done = (state == MDU_BUSY) && (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX forwarding, load-use/branch/MDU stalls.
// Define HAZARD_PERF_CNT_EN to build the saturating stall-cycle counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs_a,
    input  logic [REG_AW-1:0] id_rt_a,
    input  logic [REG_AW-1:0] ex_rs_a,
    input  logic [REG_AW-1:0] ex_rt_a,
    input  logic [REG_AW-1:0] ex_rd_a,
    input  logic [REG_AW-1:0] mem_rd_a,
    input  logic [REG_AW-1:0] wb_rd_a,
    input  logic              id_branch,
    input  logic              id_mdu_start,
    input  logic              id_mdu_read,
    input  logic              ex_RegWrite,
    input  logic              ex_MemToReg,
    input  logic              mem_RegWrite,
    input  logic              mem_MemToReg,
    input  logic              wb_RegWrite,
    input  logic              ex_mdu_start,
    output logic [1:0]        ex_forward_a,
    output logic [1:0]        ex_forward_b,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushE,
    output logic              mdu_busy,
    output logic              mdu_done,
    output logic [2:0]        stall_cause,
    output logic [CNT_W-1:0]  stall_cycles
);

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        if (mem_RegWrite && !mem_MemToReg && mem_rd_a != '0 && mem_rd_a == src)
            return FWD_MEM;
        else if (wb_RegWrite && wb_rd_a != '0 && wb_rd_a == src)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    function automatic logic branch_dep(input logic [REG_AW-1:0] src);
        return (src != '0) &&
               ((ex_RegWrite && src == ex_rd_a) || (mem_RegWrite && src == mem_rd_a));
    endfunction

    logic stall_any;

    assign ex_forward_a = fwd_sel(ex_rs_a);
    assign ex_forward_b = fwd_sel(ex_rt_a);

    always_comb begin
        stall_cause = '0;
        stall_cause[CAUSE_LOAD_USE] = ex_MemToReg && ex_rd_a != '0 &&
                                      (ex_rd_a == id_rs_a || ex_rd_a == id_rt_a);
        stall_cause[CAUSE_BRANCH]   = id_branch && (branch_dep(id_rs_a) || branch_dep(id_rt_a));
        stall_cause[CAUSE_MDU]      = (mdu_busy || ex_mdu_start) && (id_mdu_read || id_mdu_start);
    end

    assign stall_any = |stall_cause;
    assign StallF    = stall_any;
    assign StallD    = stall_any;
    assign FlushE    = stall_any;

    hazard_mdu_tracker #(
        .MDU_LATENCY (MDU_LATENCY)
    ) u_mdu (
        .clk       (clk),
        .rst       (rst),
        .mdu_start (ex_mdu_start),
        .mdu_busy  (mdu_busy),
        .mdu_done  (mdu_done)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall_any && !(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: remaining-cycle MDU model plus directed literal checks.
module tb_hazard_ctrl;

    localparam int AW  = 5;
    localparam int LAT = 4;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic rst;
    logic [AW-1:0] id_rs_a, id_rt_a, ex_rs_a, ex_rt_a, ex_rd_a, mem_rd_a, wb_rd_a;
    logic id_branch, id_mdu_start, id_mdu_read;
    logic ex_RegWrite, ex_MemToReg, mem_RegWrite, mem_MemToReg, wb_RegWrite, ex_mdu_start;
    logic [1:0] ex_forward_a, ex_forward_b;
    logic StallF, StallD, FlushE, mdu_busy, mdu_done;
    logic [2:0] stall_cause;
    logic [CW-1:0] stall_cycles;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    // model state: busy cycles still to come (including the current one)
    int busy_left = 0;
    int perf      = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(AW), .MDU_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs_a(id_rs_a), .id_rt_a(id_rt_a),
        .ex_rs_a(ex_rs_a), .ex_rt_a(ex_rt_a), .ex_rd_a(ex_rd_a),
        .mem_rd_a(mem_rd_a), .wb_rd_a(wb_rd_a),
        .id_branch(id_branch), .id_mdu_start(id_mdu_start), .id_mdu_read(id_mdu_read),
        .ex_RegWrite(ex_RegWrite), .ex_MemToReg(ex_MemToReg),
        .mem_RegWrite(mem_RegWrite), .mem_MemToReg(mem_MemToReg),
        .wb_RegWrite(wb_RegWrite), .ex_mdu_start(ex_mdu_start),
        .ex_forward_a(ex_forward_a), .ex_forward_b(ex_forward_b),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .mdu_busy(mdu_busy), .mdu_done(mdu_done),
        .stall_cause(stall_cause), .stall_cycles(stall_cycles)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int m_fwd(input logic [AW-1:0] src);
        if (mem_RegWrite && !mem_MemToReg && mem_rd_a != 0 && mem_rd_a == src) return 2;
        if (wb_RegWrite && wb_rd_a != 0 && wb_rd_a == src) return 1;
        return 0;
    endfunction

    function automatic bit m_br_dep(input logic [AW-1:0] src);
        return src != 0 && ((ex_RegWrite && src == ex_rd_a) || (mem_RegWrite && src == mem_rd_a));
    endfunction

    function automatic int m_cause();
        int c = 0;
        if (ex_MemToReg && ex_rd_a != 0 && (ex_rd_a == id_rs_a || ex_rd_a == id_rt_a)) c += 1;
        if (id_branch && (m_br_dep(id_rs_a) || m_br_dep(id_rt_a))) c += 2;
        if ((busy_left > 0 || ex_mdu_start) && (id_mdu_read || id_mdu_start)) c += 4;
        return c;
    endfunction

    always @(posedge clk) begin
        int stall;
        stall = (m_cause() != 0);
        if (rst) begin
            busy_left = 0;
            perf      = 0;
        end else begin
            if (ex_mdu_start) chk("start_legal", busy_left > 1, 0);
            if (ex_mdu_start && busy_left <= 1) busy_left = LAT;
            else if (busy_left > 0) busy_left--;
`ifdef HAZARD_PERF_CNT_EN
            if (stall && perf < (1 << CW) - 1) perf++;
`endif
        end
        if (rst) chk_en = 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int c;
            c = m_cause();
            chk("fwd_a", ex_forward_a, m_fwd(ex_rs_a));
            chk("fwd_b", ex_forward_b, m_fwd(ex_rt_a));
            chk("cause", stall_cause, c);
            chk("StallF", StallF, c != 0);
            chk("StallD", StallD, c != 0);
            chk("FlushE", FlushE, c != 0);
            chk("busy", mdu_busy, busy_left > 0);
            chk("done", mdu_done, busy_left == 1);
            chk("perf", stall_cycles, perf);
        end
    end

    task automatic clear();
        {id_rs_a, id_rt_a, ex_rs_a, ex_rt_a, ex_rd_a, mem_rd_a, wb_rd_a} = '0;
        {id_branch, id_mdu_start, id_mdu_read, ex_RegWrite, ex_MemToReg} = '0;
        {mem_RegWrite, mem_MemToReg, wb_RegWrite, ex_mdu_start} = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clear();
        step(); step();
        #2;
        chk("rst_fwd_a", ex_forward_a, 0);
        chk("rst_cause", stall_cause, 0);
        chk("rst_busy", mdu_busy, 0);
        chk("rst_perf", stall_cycles, 0);
        rst = 1'b0;

        // forwarding: MEM beats WB, zero register never forwards from MEM
        step();
        mem_RegWrite = 1; mem_rd_a = 8; wb_RegWrite = 1; wb_rd_a = 8;
        ex_rs_a = 8; ex_rt_a = 9;
        #2;
        chk("lit_fwd_mem_a", ex_forward_a, 2);
        chk("lit_fwd_mem_b", ex_forward_b, 0);
        step();
        mem_rd_a = 0;
        #2;
        chk("lit_fwd_wb_a", ex_forward_a, 1);
        step();
        mem_rd_a = 8; mem_MemToReg = 1; ex_rt_a = 8;
        #2;
        chk("lit_fwd_ld_b", ex_forward_b, 1);

        // load-use
        step(); clear();
        ex_MemToReg = 1; ex_rd_a = 5; id_rt_a = 5;
        #2;
        chk("lit_lu_cause", stall_cause, 1);
        chk("lit_lu_stallf", StallF, 1);
        chk("lit_lu_flush", FlushE, 1);
        step();
        ex_rd_a = 0; id_rt_a = 0;
        #2;
        chk("lit_lu_r0", StallD, 0);

        // branch
        step(); clear();
        id_branch = 1; id_rs_a = 3; mem_RegWrite = 1; mem_rd_a = 3;
        #2;
        chk("lit_br_cause", stall_cause, 2);
        step();
        ex_RegWrite = 1; ex_rd_a = 3; ex_MemToReg = 1;
        #2;
        chk("lit_br_lu_cause", stall_cause, 3);

        // MDU latency with mfhi waiting in ID
        step(); clear();
        id_mdu_read = 1; ex_mdu_start = 1;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) begin step(); ex_mdu_start = 0; end
            #2;
            chk($sformatf("lit_mdu_busy%0d", c), mdu_busy, (c >= 1 && c <= 4));
            chk($sformatf("lit_mdu_done%0d", c), mdu_done, c == 4);
            chk($sformatf("lit_mdu_stall%0d", c), StallD, c <= 4);
        end

        // reset mid-operation
        step(); clear();
        ex_mdu_start = 1;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) begin step(); ex_mdu_start = 0; rst = (c == 2); end
            #2;
            chk($sformatf("lit_abort_busy%0d", c), mdu_busy, (c == 1 || c == 2));
            chk($sformatf("lit_abort_done%0d", c), mdu_done, 0);
        end
        rst = 0;

        // back-to-back restart on the done cycle
        step(); clear();
        ex_mdu_start = 1;
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) begin step(); ex_mdu_start = (c == 4); end
            #2;
            chk($sformatf("lit_b2b_busy%0d", c), mdu_busy, (c >= 1 && c <= 8));
            chk($sformatf("lit_b2b_done%0d", c), mdu_done, (c == 4 || c == 8));
        end

        // stall counter saturation
        step(); clear(); rst = 1;
        step(); rst = 0;
        ex_MemToReg = 1; ex_rd_a = 7; id_rs_a = 7;
        repeat (20) step();
        clear();
        #2;
`ifdef HAZARD_PERF_CNT_EN
        chk("lit_perf_sat", stall_cycles, 15);
`else
        chk("lit_perf_off", stall_cycles, 0);
`endif

        // random sweep against the model
        for (int i = 0; i < 300; i++) begin
            step();
            id_rs_a = AW'($urandom_range(0, 3)); id_rt_a = AW'($urandom_range(0, 3));
            ex_rs_a = AW'($urandom_range(0, 3)); ex_rt_a = AW'($urandom_range(0, 3));
            ex_rd_a = AW'($urandom_range(0, 3)); mem_rd_a = AW'($urandom_range(0, 3));
            wb_rd_a = AW'($urandom_range(0, 3));
            {id_branch, id_mdu_start, id_mdu_read, ex_RegWrite, ex_MemToReg} = 5'($urandom);
            {mem_RegWrite, mem_MemToReg, wb_RegWrite} = 3'($urandom);
            ex_mdu_start = (busy_left <= 1) && ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 63) == 0);
        end
        step(); clear(); rst = 0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
